// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer RAM port arbiter.
package fb_pkg;
  localparam int unsigned FB_WIDTH  = 640;
  localparam int unsigned FB_HEIGHT = 480;
  localparam int unsigned FB_PIX_W  = 3;
  localparam int unsigned FB_ADDR_W = 19;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} fb_wr_state_t;

  typedef logic [FB_PIX_W-1:0] pixel_t;
endpackage

// File: rtl/fb_row_shifter.sv
// Row buffer: parallel-loads a whole row, shifts one pixel per write, pixel 0 first.
module fb_row_shifter
  import fb_pkg::*;
#(
  parameter int unsigned WIDTH = FB_WIDTH,
  parameter int unsigned PIX_W = FB_PIX_W
) (
  input  logic                   clk_sys,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [PIX_W*WIDTH-1:0] load_data,
  input  logic                   shift,
  output logic [PIX_W-1:0]       pix
);

  logic [PIX_W*WIDTH-1:0] row_q, row_d;

  always_comb begin
    row_d = row_q;
    if (load) begin
      row_d = load_data;
    end else if (shift) begin
      row_d = {{PIX_W{1'b0}}, row_q[PIX_W*WIDTH-1:PIX_W]};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) row_q <= '0;
    else        row_q <= row_d;
  end

  assign pix = row_q[PIX_W-1:0];

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer RAM arbiter: VGA reads win every cycle, UART rows are
// serialised into pixel writes in the cycles the reader leaves free.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned WIDTH  = FB_WIDTH,
  parameter int unsigned HEIGHT = FB_HEIGHT,
  parameter int unsigned PIX_W  = FB_PIX_W,
  parameter int unsigned ADDR_W = FB_ADDR_W
) (
  input  logic                   clk_sys,
  input  logic                   rst_n,
  input  logic                   rd_req,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic                   rd_valid,
  output logic [PIX_W-1:0]       rd_data,
  input  logic                   wr_row_valid,
  input  logic [8:0]             wr_row,
  input  logic [PIX_W*WIDTH-1:0] wr_row_data,
  output logic                   wr_row_ready,
  output logic                   wr_done,
  output logic                   err_row,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic                   ram_wren,
  output logic [PIX_W-1:0]       ram_data,
  input  logic [PIX_W-1:0]       ram_q
);

  fb_wr_state_t      state_q, state_d;
  logic [9:0]        col_q, col_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              err_row_q, err_row_d;
  logic [1:0]        rd_pipe_q, rd_pipe_d;
  logic              load, shift, grant_wr;
  logic [PIX_W-1:0]  cur_pix;

  fb_row_shifter #(
    .WIDTH (WIDTH),
    .PIX_W (PIX_W)
  ) u_shifter (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (wr_row_data),
    .shift     (shift),
    .pix       (cur_pix)
  );

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    base_d    = base_q;
    err_row_d = err_row_q;
    load      = 1'b0;
    shift     = 1'b0;
    grant_wr  = (state_q == WRITE) && !rd_req;
    rd_pipe_d = {rd_pipe_q[0], rd_req};

    unique case (state_q)
      IDLE: begin
        if (wr_row_valid) begin
          if (wr_row < 9'(HEIGHT)) begin
            load    = 1'b1;
            base_d  = ADDR_W'(wr_row) * ADDR_W'(WIDTH);
            col_d   = '0;
            state_d = WRITE;
          end else begin
            err_row_d = 1'b1;
          end
        end
      end
      WRITE: begin
        if (grant_wr) begin
          shift = 1'b1;
          if (col_q == 10'(WIDTH - 1)) begin
            col_d   = '0;
            state_d = DONE;
          end else begin
            col_d = col_q + 10'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      col_q     <= '0;
      base_q    <= '0;
      err_row_q <= 1'b0;
      rd_pipe_q <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      base_q    <= base_d;
      err_row_q <= err_row_d;
      rd_pipe_q <= rd_pipe_d;
    end
  end

  // RAM port is steered combinationally so a read address reaches the RAM in its request cycle.
  assign ram_wren     = grant_wr;
  assign ram_addr     = grant_wr ? (base_q + ADDR_W'(col_q)) : rd_addr;
  assign ram_data     = grant_wr ? cur_pix : '0;

  assign rd_valid     = rd_pipe_q[1];
  assign rd_data      = ram_q;
  assign wr_row_ready = (state_q == IDLE);
  assign wr_done      = (state_q == DONE);
  assign err_row      = err_row_q;

endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Arbiter and write sequencer for the single-port 3-bit framebuffer RAM (640×480, 19-bit address). It shares the one RAM port between the VGA pixel-fetch requester, which has absolute priority, and the UART row writer, which supplies one complete row of pixels per transfer. The block drives the RAM's address, write-enable and data ports directly, serialises each row into individual pixel writes, and returns read data with fixed latency.

## Interface
- WIDTH, 640, pixels per row
- HEIGHT, 480, rows per frame
- PIX_W, 3, bits per pixel
- ADDR_W, 19, RAM address width
- clk_sys  in  1  system clock; all logic is on its rising edge
- rst_n  in  1  reset; synchronous, active-low
- rd_req  in  1  VGA read request; address is valid in the same cycle
- rd_addr  in  ADDR_W  VGA read address
- rd_valid  out  1  read data valid, exactly 2 cycles after rd_req
- rd_data  out  PIX_W  read pixel (carries ram_q)
- wr_row_valid  in  1  row write request
- wr_row  in  9  target row index
- wr_row_data  in  PIX_W*WIDTH  row pixels; pixel 0 is in bits [PIX_W-1:0]
- wr_row_ready  out  1  high in IDLE only
- wr_done  out  1  one-cycle pulse after the last pixel of a row is written
- err_row  out  1  sticky flag: a row was rejected because wr_row ≥ HEIGHT
- ram_addr  out  ADDR_W  RAM address
- ram_wren  out  1  RAM write enable
- ram_data  out  PIX_W  RAM write data
- ram_q  in  PIX_W  RAM registered output

## Operation
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - wr_row_ready=1.
  - On wr_row_valid with wr_row<HEIGHT: latch the row data into the shifter, set base = wr_row*WIDTH (ADDR_W bits, computed once at accept), set col=0, go to WRITE.
  - On wr_row_valid with wr_row≥HEIGHT: set err_row and stay in IDLE. err_row is cleared only by reset.
- WRITE: port grant is decided combinationally each cycle.
  - If rd_req=1: ram_addr=rd_addr, ram_wren=0. The write stalls and col holds.
  - Otherwise: ram_addr=base+col, ram_wren=1, ram_data=shifter[PIX_W-1:0]. The shifter shifts right by PIX_W and col increments.
  - When the write with col=WIDTH-1 completes, go to DONE.
- DONE: wr_done=1 for one cycle, then go to IDLE.
- Reads are served in every state. Outside WRITE, ram_addr=rd_addr and ram_wren=0; when rd_req=0 in those states, ram_addr holds rd_addr.
- The read pipeline is a 2-stage valid shift register: rd_valid = rd_req delayed by 2 cycles; rd_data = ram_q.
- wr_row_valid while not in IDLE is ignored. The requester must hold the request until it sees wr_row_ready.
- Reset mid-row: the FSM returns to IDLE and the remaining pixels are not written. RAM contents are left partial and are not scrubbed.

## Timing
- Reset values: rd_valid=0, rd_data=0, wr_row_ready=1, wr_done=0, err_row=0, ram_wren=0, ram_addr=0, ram_data=0. The FSM resets to IDLE, col=0 and the pipeline is cleared.
- Accept in cycle t (IDLE & wr_row_valid):
  - Earliest first write is t+1.
  - With no reads, writes occur in t+1..t+WIDTH, wr_done is high at t+WIDTH+1, and wr_row_ready returns at t+WIDTH+2.
  - Each cycle with rd_req=1 during WRITE delays completion by exactly one cycle.
- Read latency is fixed at 2 cycles regardless of FSM state.
- Reads are never delayed by writes. Write progress during active video depends on blanking gaps; the VGA controller provides at least 160 idle cycles per line.
- Multiplier: base is computed at accept and registered. The adder base+col is the only per-cycle arithmetic. col is 10 bits.

## Structure
- Shared package fb_pkg:
  - Constants FB_WIDTH, FB_HEIGHT, FB_PIX_W, FB_ADDR_W.
  - typedef enum logic [1:0] {IDLE, WRITE, DONE} fb_wr_state_t.
  - typedef logic [FB_PIX_W-1:0] pixel_t.
- One sub-module, fb_row_shifter:
  - Parallel load of PIX_W*WIDTH bits, with a shift-by-PIX_W enable.
  - Exposes the current pixel.

## Test plan
- Reset, then idle: all outputs at their reset values. rd_req pulse at addr 5 gives rd_valid 2 cycles later with rd_data equal to the preloaded RAM[5].
- Row write, no reads: wr_row=2, pixel i = i%8. Required: 640 consecutive writes at addresses 1280..1919 with data i%8, and wr_done exactly 641 cycles after accept.
- Interleaved reads: same row with rd_req asserted on alternate cycles. Required: no ram_wren in any rd_req cycle, all 640 writes complete, wr_done at accept+1281, and read data matches preloaded values.
- Invalid row: wr_row=480. Required: err_row=1 (sticky), no ram_wren, FSM stays in IDLE.
- Last row boundary: wr_row=479. Final write address is 307199 with no wrap.
- Reset at col=100: FSM returns to IDLE, wr_row_ready=1, no wr_done. A fresh row then completes normally.
